// File: rtl/knapsack_pkg.sv
// Shared types and sizing helpers for the sequential knapsack reference solver.
package knapsack_pkg;

    localparam int DEF_N_ITEMS = 5;
    localparam int DEF_W       = 5;

    typedef enum logic [2:0] {
        IDLE,
        ACCUM,
        CHECK,
        EMIT,
        NEXT,
        DONE
    } state_t;

    // Enough headroom that summing every item at full scale cannot wrap.
    function automatic int sum_width(input int n, input int w);
        return w + $clog2(n + 1);
    endfunction

endpackage

// File: rtl/knapsack_scan_if.sv
// Candidate stream from the knapsack scanner: one feasible mask plus its sums per transfer.
interface knapsack_scan_if
    import knapsack_pkg::*;
#(
    parameter int N_ITEMS = DEF_N_ITEMS,
    parameter int SW      = sum_width(DEF_N_ITEMS, DEF_W)
) ();

    logic               out_valid;
    logic               out_ready;
    logic [N_ITEMS-1:0] out_mask;
    logic [SW-1:0]      out_value;
    logic [SW-1:0]      out_weight;

    modport master (
        output out_valid,
        output out_mask,
        output out_value,
        output out_weight,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_mask,
        input  out_value,
        input  out_weight,
        output out_ready
    );

endinterface

// File: rtl/knapsack_accum.sv
// Serial weight/value accumulator: adds one item per enabled cycle into SW-wide sums.
module knapsack_accum
    import knapsack_pkg::*;
#(
    parameter int W  = DEF_W,
    parameter int SW = sum_width(DEF_N_ITEMS, DEF_W)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          add_en,
    input  logic [W-1:0]  w_in,
    input  logic [W-1:0]  v_in,
    output logic [SW-1:0] weight_sum,
    output logic [SW-1:0] value_sum
);

    logic [SW-1:0] weight_sum_reg;
    logic [SW-1:0] value_sum_reg;

    // Clear wins over add so a new mask always starts from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            weight_sum_reg <= '0;
            value_sum_reg  <= '0;
        end else if (clr) begin
            weight_sum_reg <= '0;
            value_sum_reg  <= '0;
        end else if (add_en) begin
            weight_sum_reg <= weight_sum_reg + SW'(w_in);
            value_sum_reg  <= value_sum_reg + SW'(v_in);
        end
    end

    assign weight_sum = weight_sum_reg;
    assign value_sum  = value_sum_reg;

endmodule

// File: rtl/knapsack_scan.sv
// Exhaustive knapsack scanner: walks every selection mask, streams feasible ones
// in ascending order and keeps the best (highest value, earliest on ties).
module knapsack_scan
    import knapsack_pkg::*;
#(
    parameter int N_ITEMS = DEF_N_ITEMS,
    parameter int W       = DEF_W,
    parameter int SW      = sum_width(N_ITEMS, W)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [N_ITEMS*W-1:0] weights,
    input  logic [N_ITEMS*W-1:0] values,
    input  logic [SW-1:0]        capacity,
    input  logic [SW-1:0]        min_value,
    output logic                 busy,
    knapsack_scan_if.master      out_if,
    output logic                 done,
    output logic                 best_valid,
    output logic [N_ITEMS-1:0]   best_mask,
    output logic [SW-1:0]        best_value
);

    localparam int IDX_W = $clog2(N_ITEMS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ITEMS - 1);

    state_t               state_reg;
    logic [N_ITEMS-1:0]   mask_reg;
    logic [IDX_W-1:0]     idx_reg;
    logic [N_ITEMS*W-1:0] weights_reg;
    logic [N_ITEMS*W-1:0] values_reg;
    logic [SW-1:0]        cap_reg;
    logic [SW-1:0]        minv_reg;
    logic                 busy_reg;
    logic                 done_reg;
    logic                 best_valid_reg;
    logic [N_ITEMS-1:0]   best_mask_reg;
    logic [SW-1:0]        best_value_reg;
    logic                 ov_reg;
    logic [N_ITEMS-1:0]   om_reg;
    logic [SW-1:0]        oval_reg;
    logic [SW-1:0]        ow_reg;

    logic [W-1:0]  item_w [N_ITEMS];
    logic [W-1:0]  item_v [N_ITEMS];
    logic [SW-1:0] weight_sum;
    logic [SW-1:0] value_sum;
    logic          accum_clr;
    logic          accum_add;
    logic          feasible;
    logic          better;

    for (genvar gi = 0; gi < N_ITEMS; gi++) begin : g_item
        assign item_w[gi] = weights_reg[gi*W +: W];
        assign item_v[gi] = values_reg[gi*W +: W];
    end

    assign accum_clr = ((state_reg == IDLE) && start) || (state_reg == NEXT);
    assign accum_add = (state_reg == ACCUM) && mask_reg[idx_reg];

    knapsack_accum #(.W(W), .SW(SW)) u_accum (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (accum_clr),
        .add_en     (accum_add),
        .w_in       (item_w[idx_reg]),
        .v_in       (item_v[idx_reg]),
        .weight_sum (weight_sum),
        .value_sum  (value_sum)
    );

    assign feasible = (value_sum >= minv_reg) && (weight_sum <= cap_reg);
    // Strictly greater: an equal value found later never displaces the lower mask.
    assign better   = !best_valid_reg || (value_sum > best_value_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            mask_reg       <= '0;
            idx_reg        <= '0;
            weights_reg    <= '0;
            values_reg     <= '0;
            cap_reg        <= '0;
            minv_reg       <= '0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            best_valid_reg <= 1'b0;
            best_mask_reg  <= '0;
            best_value_reg <= '0;
            ov_reg         <= 1'b0;
            om_reg         <= '0;
            oval_reg       <= '0;
            ow_reg         <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        weights_reg    <= weights;
                        values_reg     <= values;
                        cap_reg        <= capacity;
                        minv_reg       <= min_value;
                        mask_reg       <= '0;
                        idx_reg        <= '0;
                        best_valid_reg <= 1'b0;
                        best_mask_reg  <= '0;
                        best_value_reg <= '0;
                        busy_reg       <= 1'b1;
                        state_reg      <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (idx_reg == LAST_IDX) begin
                        state_reg <= CHECK;
                    end else begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end
                CHECK: begin
                    if (feasible) begin
                        if (better) begin
                            best_valid_reg <= 1'b1;
                            best_mask_reg  <= mask_reg;
                            best_value_reg <= value_sum;
                        end
                        ov_reg    <= 1'b1;
                        om_reg    <= mask_reg;
                        oval_reg  <= value_sum;
                        ow_reg    <= weight_sum;
                        state_reg <= EMIT;
                    end else begin
                        state_reg <= NEXT;
                    end
                end
                EMIT: begin
                    if (out_if.out_ready) begin
                        ov_reg    <= 1'b0;
                        state_reg <= NEXT;
                    end
                end
                NEXT: begin
                    if (&mask_reg) begin
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end else begin
                        mask_reg  <= mask_reg + 1'b1;
                        idx_reg   <= '0;
                        state_reg <= ACCUM;
                    end
                end
                DONE: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy              = busy_reg;
    assign done              = done_reg;
    assign best_valid        = best_valid_reg;
    assign best_mask         = best_mask_reg;
    assign best_value        = best_value_reg;
    assign out_if.out_valid  = ov_reg;
    assign out_if.out_mask   = om_reg;
    assign out_if.out_value  = oval_reg;
    assign out_if.out_weight = ow_reg;

endmodule

// File: tb/tb_knapsack_scan.sv
// Scoreboard bench for knapsack_scan: expected candidates are queued at stimulus time
// and a monitor pops and compares them on every accepted transfer.
module tb_knapsack_scan;
    import knapsack_pkg::*;

    localparam int N  = 5;
    localparam int W  = 5;
    localparam int SW = sum_width(N, W);

    typedef struct packed {
        logic [N-1:0]  mask;
        logic [SW-1:0] value;
        logic [SW-1:0] weight;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [N*W-1:0] weights = '0;
    logic [N*W-1:0] values = '0;
    logic [SW-1:0] capacity = '0;
    logic [SW-1:0] min_value = '0;
    logic          busy;
    logic          done;
    logic          best_valid;
    logic [N-1:0]  best_mask;
    logic [SW-1:0] best_value;

    knapsack_scan_if #(.N_ITEMS(N), .SW(SW)) oif ();

    knapsack_scan #(.N_ITEMS(N), .W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .weights    (weights),
        .values     (values),
        .capacity   (capacity),
        .min_value  (min_value),
        .busy       (busy),
        .out_if     (oif),
        .done       (done),
        .best_valid (best_valid),
        .best_mask  (best_mask),
        .best_value (best_value)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int   cur_w [N] = '{12, 1, 2, 1, 4};
    int   cur_v [N] = '{4, 2, 2, 1, 10};
    exp_t exp_q [$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   done_cnt = 0;
    int   done_cyc = 0;
    int   emit_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [N*W-1:0] pack(input int a [N]);
        logic [N*W-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) r[i*W +: W] = W'(a[i]);
        return r;
    endfunction

    task automatic push_all(input int cap, input int minv);
        exp_t e;
        for (int m = 0; m < (1 << N); m++) begin
            int ws = 0;
            int vs = 0;
            for (int i = 0; i < N; i++) begin
                if (m[i]) begin
                    ws += cur_w[i];
                    vs += cur_v[i];
                end
            end
            if (vs >= minv && ws <= cap) begin
                e.mask = N'(m);
                e.value = SW'(vs);
                e.weight = SW'(ws);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic push_one(input int m, input int v, input int w);
        exp_t e;
        e.mask = N'(m);
        e.value = SW'(v);
        e.weight = SW'(w);
        exp_q.push_back(e);
    endtask

    task automatic check_zero(input string name);
        check(name, {26'd0, busy, done, best_valid, best_mask, best_value,
                     oif.out_valid, oif.out_mask, oif.out_value, oif.out_weight}, 64'd0);
    endtask

    // Monitor: samples 1 time unit after the falling edge, well clear of the active edge.
    logic          prev_hold = 1'b0;
    logic [N-1:0]  prev_mask;
    logic [SW-1:0] prev_value;
    logic [SW-1:0] prev_weight;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (rst_n && prev_hold)
                check("hold_stable", {oif.out_mask, oif.out_value, oif.out_weight},
                      {prev_mask, prev_value, prev_weight});
            prev_hold   = rst_n && oif.out_valid && !oif.out_ready;
            prev_mask   = oif.out_mask;
            prev_value  = oif.out_value;
            prev_weight = oif.out_weight;
            if (rst_n && oif.out_valid && oif.out_ready) begin
                emit_cnt++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL emit_unexpected: got mask %b, expected no transfer", oif.out_mask);
                end else begin
                    e = exp_q.pop_front();
                    check("emit_mask", 64'(oif.out_mask), 64'(e.mask));
                    check("emit_value", 64'(oif.out_value), 64'(e.value));
                    check("emit_weight", 64'(oif.out_weight), 64'(e.weight));
                end
            end
        end
    end

    task automatic run_scan(input string tag, input int cap, input int minv, input int exp_lat,
                            input int exp_emits, input logic exp_bv, input int exp_bm,
                            input int exp_bval, input int stall, input bit poke);
        int t0;
        int cnt = 0;
        int stall_cnt = 0;
        bit released = 1'b0;
        @(negedge clk);
        weights   = pack(cur_w);
        values    = pack(cur_v);
        capacity  = SW'(cap);
        min_value = SW'(minv);
        oif.out_ready = (stall == 0);
        done_cnt = 0;
        emit_cnt = 0;
        start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy"}, 64'(busy), 64'd1);
        while (done_cnt == 0 && cnt < 3000) begin
            @(negedge clk);
            cnt++;
            if (stall > 0 && oif.out_valid && !released) begin
                stall_cnt++;
                if (stall_cnt > stall) begin
                    oif.out_ready = 1'b1;
                    released = 1'b1;
                end
            end
            if (poke) begin
                start   = ((cnt % 5) == 0) && !done;
                weights = N*W'($urandom);
                capacity = SW'($urandom);
            end
            #2;
        end
        start = 1'b0;
        oif.out_ready = 1'b1;
        if (done_cnt == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: got no done in %0d cycles, expected done", tag, cnt);
        end else begin
            check({tag, "_latency"}, 64'(done_cyc - t0), 64'(exp_lat));
        end
        repeat (3) @(negedge clk);
        #2;
        check({tag, "_done_once"}, 64'(done_cnt), 64'd1);
        check({tag, "_busy_fall"}, 64'(busy), 64'd0);
        check({tag, "_emits"}, 64'(emit_cnt), 64'(exp_emits));
        check({tag, "_best_valid"}, 64'(best_valid), 64'(exp_bv));
        check({tag, "_best_mask"}, 64'(best_mask), 64'(exp_bm));
        check({tag, "_best_value"}, 64'(best_value), 64'(exp_bval));
        check({tag, "_queue_left"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected bench to end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        oif.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        check_zero("reset_in");
        rst_n = 1'b1;
        @(negedge clk);
        #2;
        check_zero("reset_out");

        // Single feasible mask 11110 (value 15, weight 8); 32*7 + 1 + 1 cycles.
        push_one(5'b11110, 15, 8);
        run_scan("t1", 16, 15, 226, 1, 1'b1, 5'b11110, 15, 0, 1'b0);

        // Everything feasible: 32 ascending emits, 32*7 + 32 + 1 cycles.
        push_all(31, 0);
        run_scan("t2", 31, 0, 257, 32, 1'b1, 5'b11111, 19, 0, 1'b0);
        check("t2_last", {oif.out_mask, oif.out_value, oif.out_weight},
              {5'b11111, 8'd19, 8'd20});

        // Case 1 with 10 cycles of backpressure on the only candidate.
        push_one(5'b11110, 15, 8);
        run_scan("t3", 16, 15, 236, 1, 1'b1, 5'b11110, 15, 10, 1'b0);

        // Nothing feasible; best state cleared by the new start.
        run_scan("t4", 0, 1, 225, 0, 1'b0, 0, 0, 0, 1'b0);

        // Start pulses and input churn mid-scan must not disturb the latched scan.
        push_all(31, 0);
        run_scan("t5a", 31, 0, 257, 32, 1'b1, 5'b11111, 19, 0, 1'b1);

        // Reset 50 cycles into a scan, then a clean rescan.
        @(negedge clk);
        weights   = pack(cur_w);
        values    = pack(cur_v);
        capacity  = SW'(31);
        min_value = SW'(0);
        push_all(31, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (49) @(negedge clk);
        #3;
        check("t5b_busy_before", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check_zero("t5b_async_reset");
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        push_one(5'b11110, 15, 8);
        run_scan("t5b", 16, 15, 226, 1, 1'b1, 5'b11110, 15, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/knapsack_scan.md
Name: knapsack_scan

Overview:
- Parametrised, sequential successor to the team's combinational knapsack constraint checker.
- Enumerates every selection mask over N_ITEMS items, accumulates weight and value one item per clock, and tests each mask against capacity and minimum-value thresholds.
- Streams each feasible mask out over a valid/ready handshake and tracks the best feasible mask.
- Used as a classical reference solver to cross-check annealer results.

Parameters:
- N_ITEMS, 5, number of items; also the selection-mask width (2..12).
- W, 5, width of each per-item weight and value.
- SW, W+$clog2(N_ITEMS+1), derived sum width; no sum can overflow.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a scan; sampled only in IDLE.
- weights  input  N_ITEMS*W  item i weight at [i*W +: W]; latched on an accepted start.
- values  input  N_ITEMS*W  item i value, same packing; latched on an accepted start.
- capacity  input  SW  inclusive weight limit; latched on an accepted start.
- min_value  input  SW  inclusive value floor; latched on an accepted start.
- busy  output  1  high from the cycle after an accepted start until DONE exits.
- out_valid  output  1  a feasible candidate is presented.
- out_ready  input  1  consumer accepts the candidate.
- out_mask  output  N_ITEMS  candidate selection; bit i = item i.
- out_value  output  SW  candidate total value.
- out_weight  output  SW  candidate total weight.
- done  output  1  one-cycle pulse at the end of the scan.
- best_valid  output  1  at least one feasible mask has been found in the current scan.
- best_mask  output  N_ITEMS  best feasible mask.
- best_value  output  SW  value of best_mask.

Behaviour:
- Reset (async assert, sync release): state=IDLE. All outputs 0, all internal registers 0.
- IDLE:
  - start=1 latches the inputs and clears mask, item index, sums and best_*; go to ACCUM.
  - start outside IDLE is ignored.
- ACCUM, one cycle per item, i = 0..N_ITEMS-1:
  - If mask[i]=1, add weight[i] and value[i] into the SW-wide sums.
  - After i=N_ITEMS-1, go to CHECK.
- CHECK, 1 cycle:
  - feasible = (value_sum >= min_value) && (weight_sum <= capacity).
  - If feasible and (!best_valid || value_sum > best_value), update best_*. Ties keep the earlier (lower) mask.
  - Feasible: go to EMIT. Otherwise: go to NEXT.
- EMIT:
  - out_valid=1 with mask and sums registered.
  - All out_* hold stable while out_ready=0.
  - Transfer completes on out_valid && out_ready; go to NEXT.
  - out_ready already high on entry: transfer completes that cycle (1-cycle EMIT).
- NEXT, 1 cycle:
  - mask == 2^N_ITEMS-1: go to DONE.
  - Otherwise: mask+1, clear sums and item index, go to ACCUM.
- DONE: done=1 for exactly one cycle, then IDLE. best_* and best_valid hold until the next accepted start.
- Cycles per mask = N_ITEMS + 2 + EMIT cycles.
- Scan length without backpressure = 2^N_ITEMS*(N_ITEMS+2) + F + 1 cycles, where F = number of feasible masks.
- Masks are emitted in strictly ascending order. Mask 0 is evaluated and is feasible iff min_value == 0.
- Inputs changing mid-scan have no effect, because they are only latched on an accepted start.
- Reset mid-scan aborts immediately. No done pulse, out_valid drops asynchronously.

Decomposition:
- Shared package knapsack_pkg:
  - state enum: IDLE, ACCUM, CHECK, EMIT, NEXT, DONE.
  - function sum_width(n, w).
  - default N_ITEMS and W constants.
- One sub-module, knapsack_accum: per-item serial weight/value accumulator with clear and add-enable inputs.
- FSM, mask counter and best tracker stay in knapsack_scan.

Test Plan:
1. N=5, W=5:
   - Stimulus: weights {12,1,2,1,4}, values {4,2,2,1,10} (item0..4), capacity=16, min_value=15, out_ready=1.
   - Response: exactly one emit, mask=5'b11110, value=15, weight=8. best_mask=5'b11110, best_value=15. done after 32*7+1+1 = 226 cycles.
2. Same items, capacity=31, min_value=0, out_ready=1:
   - Response: 32 emits, masks 0..31 ascending. Final emit value=19, weight=20. best_mask=5'b11111.
3. Case 1 with out_ready held low 10 cycles after out_valid rises:
   - Response: out_* stable all 10 cycles. Single transfer on release. done delayed by exactly 10 cycles.
4. capacity=0, min_value=1:
   - Response: no out_valid, best_valid=0, done pulses once, busy falls.
5. Edge conditions:
   - start pulsed repeatedly mid-scan: no restart, mask sequence uninterrupted.
   - rst_n low at cycle 50 of a scan: all outputs 0 asynchronously. A new start rescans from mask 0 with correct results.
